// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
// Instruction queue between MIPS fetch and decode. Buffers {pc, instruction}
// pairs in a DEPTH-entry circular buffer and presents the head entry to decode
// with the standard MIPS fields split out. flush drops every queued entry.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   flush                      discard all entries at the next clock edge
//   in_valid/in_ready          fetch handshake (in_ready = !full)
//   in_pc, in_instruction      entry payload, sampled only on push
//   out_valid/out_ready        decode handshake (out_valid = !empty)
//   out_pc, out_instruction    head entry
//   opcode..funct              instruction fields of the head entry
//   imm_sext, jump_target      sign-extended immediate, J-type target
//   pc_plus4, is_rtype         head pc + 4, opcode == 0
//   count                      number of occupied entries
module fetch_decode_queue #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instruction,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instruction,
    output logic [5:0]               opcode,
    output logic [4:0]               rs,
    output logic [4:0]               rt,
    output logic [4:0]               rd,
    output logic [4:0]               shamt,
    output logic [5:0]               funct,
    output logic [31:0]              imm_sext,
    output logic [31:0]              jump_target,
    output logic [31:0]              pc_plus4,
    output logic                     is_rtype,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    // Handshake flags depend only on the registered occupancy.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // flush suppresses both transfers in the cycle it is sampled.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Pointers, occupancy and storage; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage is intentionally left untouched.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= in_pc;
                instr_mem[wr_ptr] <= in_instruction;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Head entry and its decoded fields, combinational from rd_ptr.
    assign out_pc          = pc_mem[rd_ptr];
    assign out_instruction = instr_mem[rd_ptr];
    assign opcode          = out_instruction[31:26];
    assign rs              = out_instruction[25:21];
    assign rt              = out_instruction[20:16];
    assign rd              = out_instruction[15:11];
    assign shamt           = out_instruction[10:6];
    assign funct           = out_instruction[5:0];
    assign imm_sext        = {{16{out_instruction[15]}}, out_instruction[15:0]};
    assign pc_plus4        = out_pc + 32'd4;
    assign jump_target     = {pc_plus4[31:28], out_instruction[25:0], 2'b00};
    assign is_rtype        = (opcode == 6'b000000);

endmodule

// File: tb/tb_fetch_decode_queue.sv
`timescale 1ns/1ps
module tb_fetch_decode_queue;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instruction;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] jump_target;
    logic [31:0] pc_plus4;
    logic        is_rtype;
    logic [$clog2(DEPTH):0] count;

    fetch_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instruction(in_instruction),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instruction(out_instruction),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm_sext(imm_sext), .jump_target(jump_target), .pc_plus4(pc_plus4),
        .is_rtype(is_rtype), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        ordy;
        logic        fl;
        int unsigned cnt;
        logic        rdy;
        logic        val;
    } vec_t;

    entry_t sb[$];
    vec_t   tbl[8];
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare handshake/occupancy against the model, and the head entry plus
    // its decoded fields whenever the model holds something.
    task automatic check_state();
        logic [31:0] i;
        logic [31:0] p4;
        chk("count", 32'(count), 32'(sb.size()));
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
        if (sb.size() != 0) begin
            i  = sb[0].ins;
            p4 = sb[0].pc + 32'd4;
            chk("out_pc", out_pc, sb[0].pc);
            chk("out_instruction", out_instruction, i);
            chk("opcode", 32'(opcode), 32'(i[31:26]));
            chk("rs", 32'(rs), 32'(i[25:21]));
            chk("rt", 32'(rt), 32'(i[20:16]));
            chk("rd", 32'(rd), 32'(i[15:11]));
            chk("shamt", 32'(shamt), 32'(i[10:6]));
            chk("funct", 32'(funct), 32'(i[5:0]));
            chk("imm_sext", imm_sext, {{16{i[15]}}, i[15:0]});
            chk("pc_plus4", pc_plus4, p4);
            chk("jump_target", jump_target, {p4[31:28], i[25:0], 2'b00});
            chk("is_rtype", 32'(is_rtype), 32'(i[31:26] == 6'd0));
        end
    endtask

    // One clock of stimulus: drive at negedge, score at the edge, check #1 after.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        logic do_push;
        logic do_pop;
        @(negedge clk);
        in_valid       = v;
        in_pc          = pc;
        in_instruction = ins;
        out_ready      = ordy;
        flush          = fl;
        do_push = v && (sb.size() < DEPTH) && !fl;
        do_pop  = ordy && (sb.size() != 0) && !fl;
        if (do_pop) begin
            chk("pop_pc", out_pc, sb[0].pc);
            chk("pop_instruction", out_instruction, sb[0].ins);
        end
        @(posedge clk);
        if (fl) sb.delete();
        else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back('{pc: pc, ins: ins});
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        check_state();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instruction = '0;

        // Values during reset.
        #0.5;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_instruction", out_instruction, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_jump_target", jump_target, 32'd0);
        chk("rst_is_rtype", 32'(is_rtype), 32'd1);
        #0.5;
        reset = 1'b0;

        // Single transfer: add $t0,$t1,$t2.
        drive(1'b1, 32'h0, 32'h012A4020, 1'b0, 1'b0);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_opcode", 32'(opcode), 32'd0);
        chk("add_rs", 32'(rs), 32'd9);
        chk("add_rt", 32'(rt), 32'd10);
        chk("add_rd", 32'(rd), 32'd8);
        chk("add_funct", 32'(funct), 32'h20);
        chk("add_is_rtype", 32'(is_rtype), 32'd1);
        chk("add_count", 32'(count), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("add_drained", 32'(out_valid), 32'd0);

        // Fill, full hold-off, pop/push at occupancy 1, drain across wrap.
        tbl[0] = '{1'b1, 32'h0,  32'h8C880004, 1'b0, 1'b0, 1, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 32'h4,  32'hAD2A0008, 1'b0, 1'b0, 2, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 32'h8,  32'h1109FFFE, 1'b0, 1'b0, 2, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 32'h8,  32'h1109FFFE, 1'b1, 1'b0, 1, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 32'h8,  32'h1109FFFE, 1'b1, 1'b0, 1, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 32'hC,  32'h00094080, 1'b0, 1'b0, 2, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 32'h10, 32'h3C01ABCD, 1'b1, 1'b0, 1, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 0, 1'b1, 1'b0};
        for (int k = 0; k < 8; k++) begin
            drive(tbl[k].v, tbl[k].pc, tbl[k].ins, tbl[k].ordy, tbl[k].fl);
            chk($sformatf("vec%0d_count", k), 32'(count), 32'(tbl[k].cnt));
            chk($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(tbl[k].rdy));
            chk($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].val));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("pop_on_empty", 32'(count), 32'd0);

        // Immediate and jump decode.
        drive(1'b1, 32'h100, 32'h2108FFFF, 1'b0, 1'b0);
        chk("addi_imm_sext", imm_sext, 32'hFFFFFFFF);
        drive(1'b1, 32'h104, 32'h08000010, 1'b1, 1'b0);
        chk("j_jump_target", jump_target, 32'h00000040);
        chk("j_pc_plus4", pc_plus4, 32'h108);
        chk("j_is_rtype", 32'(is_rtype), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with concurrent push and pop while full.
        drive(1'b1, 32'h200, 32'h01095020, 1'b0, 1'b0);
        drive(1'b1, 32'h204, 32'h01095022, 1'b0, 1'b0);
        drive(1'b1, 32'h208, 32'h01095024, 1'b1, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 32'h300, 32'h24020005, 1'b0, 1'b0);
        chk("post_flush_head", out_pc, 32'h300);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Reset between clock edges with two entries held.
        drive(1'b1, 32'h380, 32'h00851820, 1'b0, 1'b0);
        drive(1'b1, 32'h384, 32'h00851822, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        sb.delete();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_pc", out_pc, 32'd0);
        #1;
        reset = 1'b0;
        drive(1'b1, 32'h400, 32'h8FBF0010, 1'b0, 1'b0);
        chk("after_rst_head", out_pc, 32'h400);
        drive(1'b1, 32'h404, 32'h03E00008, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
